sgpio_frame_sched: RTL and testbench

SGPIO_FRAME_SCHED -- requirements
Module: sgpio_frame_sched

---
 rtl/sgpio_frame_sched.sv | 202 ++++++++++++++++++++
 tb/tb_sgpio_frame_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sgpio_frame_sched.sv
// sgpio_frame_sched -- builds SGPIO drive-status frames and offers them to the
// serializer with a ready/valid handshake, an accept timeout and an
// inter-frame gap.
//
// Build option: define SGPIO_BLINK_EN to make the LOC bit blink at the
// BLINK_DIV half period. Without it the blink counter is not built and the
// LOC bit follows DRV_LOC directly.
//
// Frame layout: drive n occupies bits [3n+2:3n] = {FLT, LOC, ACT}.

// Per-drive lane: activity synchronizer, sticky activity and frame bits.
module sgpio_drv_lane (
    input  logic       SYSCLK,
    input  logic       RESET_N,
    input  logic       act_n,
    input  logic       loc,
    input  logic       flt,
    input  logic       blink,
    input  logic       build,
    output logic [2:0] bits
);
    logic act_s1;
    logic act_s2;
    logic act_sticky;

    // Two-flop synchronizer on the inverted (active-high) activity so reset 0 means idle.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            act_s1 <= 1'b0;
            act_s2 <= 1'b0;
        end else begin
            act_s1 <= ~act_n;
            act_s2 <= act_s1;
        end
    end

    // Sticky activity: cleared when a frame is built, but activity arriving in
    // that same cycle is kept for the following frame.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N)
            act_sticky <= 1'b0;
        else if (build)
            act_sticky <= act_s2;
        else if (act_s2)
            act_sticky <= 1'b1;
    end

    assign bits = {flt, loc & blink, act_sticky};
endmodule

module sgpio_frame_sched #(
    parameter int HDD_NUM   = 36,
    parameter int FRAME_GAP = 1000,
    parameter int BLINK_DIV = 12500000,
    parameter int TMO       = 4096
) (
    input  logic                   SYSCLK,
    input  logic                   RESET_N,
    input  logic [HDD_NUM-1:0]     DRV_ACT_N,
    input  logic [HDD_NUM-1:0]     DRV_LOC,
    input  logic [HDD_NUM-1:0]     DRV_FLT,
    input  logic                   BMC_OVR_EN,
    input  logic [3*HDD_NUM-1:0]   BMC_OVR_DATA,
    output logic                   FRAME_VLD,
    input  logic                   FRAME_RDY,
    output logic [3*HDD_NUM-1:0]   FRAME_DATA,
    output logic [15:0]            FRAME_CNT,
    output logic                   FRAME_DROP
);
    // Three-bit encoding leaves spare codes that must fall back to IDLE.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] BUILD = 3'd1;
    localparam logic [2:0] OFFER = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;

    localparam int WW = $clog2(TMO + 1);
    localparam int GW = $clog2(FRAME_GAP + 1);

    logic [2:0]                   state;
    logic [2:0]                   state_nxt;
    logic                         xfer;
    logic                         tmo_hit;
    logic [WW-1:0]                wait_cnt;
    logic [GW-1:0]                gap_cnt;
    logic [3*HDD_NUM-1:0]         frame_data;
    logic [15:0]                  frame_cnt;
    logic                         frame_drop;
    logic                         blink;
    logic                         build;
    logic [HDD_NUM-1:0][2:0]      lane_bits;

    assign build = (state == BUILD);

`ifdef SGPIO_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    logic [BW-1:0] blink_cnt;

    // Free-running blink square wave, independent of the frame state machine.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    assign blink = 1'b1;
`endif

    // One lane per drive slot.
    for (genvar i = 0; i < HDD_NUM; i++) begin : g_lane
        sgpio_drv_lane u_lane (
            .SYSCLK  (SYSCLK),
            .RESET_N (RESET_N),
            .act_n   (DRV_ACT_N[i]),
            .loc     (DRV_LOC[i]),
            .flt     (DRV_FLT[i]),
            .blink   (blink),
            .build   (build),
            .bits    (lane_bits[i])
        );
    end

    // Next-state decode; FRAME_RDY only matters while offering.
    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE:  state_nxt = BUILD;
            BUILD: state_nxt = OFFER;
            OFFER: begin
                if (FRAME_RDY) begin
                    xfer      = 1'b1;
                    state_nxt = GAP;
                end else if (wait_cnt == WW'(TMO - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP:   if (gap_cnt == GW'(FRAME_GAP - 1)) state_nxt = BUILD;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Offer wait counter: counts not-ready cycles, zero outside OFFER.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N)
            wait_cnt <= '0;
        else if (state != OFFER)
            wait_cnt <= '0;
        else if (!FRAME_RDY)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Gap counter: counts GAP cycles, zero outside GAP.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N)
            gap_cnt <= '0;
        else if (state != GAP)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + 1'b1;
    end

    // Frame image is loaded only in BUILD so it holds through the whole offer.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N)
            frame_data <= '0;
        else if (build)
            frame_data <= BMC_OVR_EN ? BMC_OVR_DATA : lane_bits;
    end

    // Accepted-frame counter (wraps naturally) and timeout pulse.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_cnt  <= '0;
            frame_drop <= 1'b0;
        end else begin
            if (xfer)
                frame_cnt <= frame_cnt + 16'd1;
            frame_drop <= tmo_hit;
        end
    end

    assign FRAME_VLD  = (state == OFFER);
    assign FRAME_DATA = frame_data;
    assign FRAME_CNT  = frame_cnt;
    assign FRAME_DROP = frame_drop;
endmodule

// File: tb/tb_sgpio_frame_sched.sv
// Directed bench for sgpio_frame_sched: expected frame images, valid-rise
// cycles and drop cycles are queued up front and consumed as the DUT offers.
module tb_sgpio_frame_sched;
    localparam int HDD_NUM   = 4;
    localparam int FRAME_GAP = 4;
    localparam int BLINK_DIV = 8;
    localparam int TMO       = 16;

`ifdef SGPIO_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic                 SYSCLK = 1'b0;
    logic                 RESET_N;
    logic [HDD_NUM-1:0]   DRV_ACT_N;
    logic [HDD_NUM-1:0]   DRV_LOC;
    logic [HDD_NUM-1:0]   DRV_FLT;
    logic                 BMC_OVR_EN;
    logic [3*HDD_NUM-1:0] BMC_OVR_DATA;
    logic                 FRAME_VLD;
    logic                 FRAME_RDY;
    logic [3*HDD_NUM-1:0] FRAME_DATA;
    logic [15:0]          FRAME_CNT;
    logic                 FRAME_DROP;

    sgpio_frame_sched #(
        .HDD_NUM(HDD_NUM), .FRAME_GAP(FRAME_GAP), .BLINK_DIV(BLINK_DIV), .TMO(TMO)
    ) dut (
        .SYSCLK(SYSCLK), .RESET_N(RESET_N), .DRV_ACT_N(DRV_ACT_N), .DRV_LOC(DRV_LOC),
        .DRV_FLT(DRV_FLT), .BMC_OVR_EN(BMC_OVR_EN), .BMC_OVR_DATA(BMC_OVR_DATA),
        .FRAME_VLD(FRAME_VLD), .FRAME_RDY(FRAME_RDY), .FRAME_DATA(FRAME_DATA),
        .FRAME_CNT(FRAME_CNT), .FRAME_DROP(FRAME_DROP)
    );

    always #5 SYSCLK = ~SYSCLK;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          offer_len = 0;
    logic        vld_prev = 1'b0;
    logic [15:0] exp_cnt = 16'd0;
    logic [11:0] data_q[$];
    int          rise_q[$];
    int          drop_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Blink level seen by a BUILD in cycle c after reset release.
    function automatic bit blink_at(input int c);
        return BLINK_ON ? (((c / BLINK_DIV) % 2) == 0) : 1'b1;
    endfunction

    // Frame with FLT on drive 3 and LOC requested on drive 0.
    function automatic logic [11:0] lf(input int c);
        return 12'h800 | (blink_at(c) ? 12'h002 : 12'h000);
    endfunction

    // One clock: sample after the edge and score every observable event.
    task automatic step();
        int r;
        @(posedge SYSCLK);
        #1;
        cyc++;
        chk("frame_cnt", FRAME_CNT, exp_cnt);
        if (FRAME_VLD && !vld_prev) begin
            chk("rise_q_nonempty", rise_q.size() > 0, 1);
            if (rise_q.size() > 0) begin
                r = rise_q.pop_front();
                chk("vld_rise_cycle", cyc, r);
            end
            offer_len = 0;
        end
        if (FRAME_VLD) begin
            offer_len++;
            chk("data_q_nonempty", data_q.size() > 0, 1);
            if (data_q.size() > 0) chk("frame_data", FRAME_DATA, data_q[0]);
        end
        if (FRAME_DROP) begin
            chk("drop_q_nonempty", drop_q.size() > 0, 1);
            if (drop_q.size() > 0) begin
                r = drop_q.pop_front();
                chk("drop_cycle", cyc, r);
            end
            chk("offer_len_at_drop", offer_len, TMO);
            if (data_q.size() > 0) void'(data_q.pop_front());
        end
        if (FRAME_VLD && FRAME_RDY) begin
            if (data_q.size() > 0) void'(data_q.pop_front());
            exp_cnt++;
        end
        vld_prev = FRAME_VLD;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        RESET_N      = 1'b0;
        DRV_ACT_N    = '1;
        DRV_LOC      = '0;
        DRV_FLT      = '0;
        BMC_OVR_EN   = 1'b0;
        BMC_OVR_DATA = '0;
        FRAME_RDY    = 1'b1;

        data_q = '{12'h000, 12'h040, lf(13), lf(19), lf(25), lf(31), lf(37),
                   lf(43), 12'hA5A, lf(70), lf(76)};
        rise_q = '{2, 8, 14, 20, 26, 32, 38, 44, 65, 71, 77};
        drop_q = '{60};

        repeat (3) @(posedge SYSCLK);
        #1;
        chk("rst_vld", FRAME_VLD, 0);
        chk("rst_data", FRAME_DATA, 0);
        chk("rst_cnt", FRAME_CNT, 0);
        chk("rst_drop", FRAME_DROP, 0);

        RESET_N = 1'b1;
        cyc = 0;

        // Single-cycle activity pulse on drive 2 during the first gap.
        run_to(3);  DRV_ACT_N[2] = 1'b0;
        run_to(4);  DRV_ACT_N[2] = 1'b1;
        run_to(8);  DRV_LOC = 4'b0001; DRV_FLT = 4'b1000;

        // Starve the next offer so it times out.
        run_to(39); FRAME_RDY = 1'b0;

        // After the drop: override frame, pending activity, counter near wrap.
        run_to(60);
        FRAME_RDY    = 1'b1;
        BMC_OVR_EN   = 1'b1;
        BMC_OVR_DATA = 12'hA5A;
        DRV_ACT_N[0] = 1'b0;
        force dut.frame_cnt = 16'hFFFE;
        #1;
        release dut.frame_cnt;
        exp_cnt = 16'hFFFE;
        run_to(61); DRV_ACT_N[0] = 1'b1;
        run_to(65); BMC_OVR_EN = 1'b0;
        run_to(72);
        chk("cnt_wrap", FRAME_CNT, 16'h0000);

        // Reset in the middle of an offer.
        run_to(76); FRAME_RDY = 1'b0;
        run_to(77);
        chk("vld_before_rst", FRAME_VLD, 1);
        RESET_N = 1'b0;
        #1;
        chk("midrst_vld", FRAME_VLD, 0);
        chk("midrst_data", FRAME_DATA, 0);
        chk("midrst_cnt", FRAME_CNT, 0);
        chk("midrst_drop", FRAME_DROP, 0);
        #1;
        RESET_N = 1'b1;
        cyc = 0;
        vld_prev = 1'b0;
        exp_cnt = 16'd0;
        FRAME_RDY = 1'b1;
        if (data_q.size() > 0) void'(data_q.pop_front());
        data_q.push_back(lf(1));
        rise_q.push_back(2);
        run_to(5);

        chk("queues_drained", data_q.size() + rise_q.size() + drop_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
